// File: rtl/mult_pkg.sv
// Shared definitions for the multi-cycle shift-add multiplier.
//   state_t   : controller states (IDLE accepts, BUSY iterates, DONE presents)
//   num_steps : number of BUSY iterations for a given operand width and
//               number of multiplier bits retired per iteration
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned num_steps(input int unsigned width,
                                              input int unsigned bits_per_cycle);
        return (bits_per_cycle == 0) ? 0 : width / bits_per_cycle;
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One iteration of the shift-add multiplier (purely combinational).
//   acc      : running 2*WIDTH-bit partial sum
//   mcand    : multiplicand magnitude
//   bits     : the BITS_PER_CYCLE multiplier bits retired this iteration
//   step     : iteration index; positions the multiplicand at step*BITS_PER_CYCLE
//   acc_next : acc plus every selected, shifted multiplicand copy
module mult_pp_step #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned STEP_W         = 4
) (
    input  logic [2*WIDTH-1:0]        acc,
    input  logic [WIDTH-1:0]          mcand,
    input  logic [BITS_PER_CYCLE-1:0] bits,
    input  logic [STEP_W-1:0]         step,
    output logic [2*WIDTH-1:0]        acc_next
);

    logic [2*WIDTH-1:0] mcand_ext;
    int unsigned        shamt;

    always_comb begin
        shamt     = 32'(step) * BITS_PER_CYCLE;
        mcand_ext = {{WIDTH{1'b0}}, mcand} << shamt;
        acc_next  = acc;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (bits[i]) begin
                acc_next = acc_next + (mcand_ext << i);
            end
        end
    end

endmodule

// File: rtl/combinational_multi_cycle_mult.sv
// Multi-cycle shift-add multiplier, signed or unsigned, with valid/ready
// handshakes on both sides.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake; in_ready is high only in IDLE
//   in1, in2          : multiplier / multiplicand (WIDTH bits)
//   signed_mode       : 1 = two's-complement operands, captured with them
//   out_valid/out_ready : product handshake; out_valid is high only in DONE
//   out               : 2*WIDTH-bit exact product, held until taken
module combinational_multi_cycle_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int unsigned N_STEPS = num_steps(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned STEP_W  = $clog2(N_STEPS + 1);
    localparam int unsigned PW      = 2 * WIDTH;

    if (WIDTH < 2 || WIDTH > 64 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
        $error("combinational_multi_cycle_mult: illegal WIDTH/BITS_PER_CYCLE");
    end

    state_t              state;
    logic [PW-1:0]       acc;
    logic [PW-1:0]       acc_next;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mplier;
    logic [WIDTH-1:0]    mag1;
    logic [WIDTH-1:0]    mag2;
    logic [STEP_W-1:0]   count;
    logic                negate;

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to
    // 2^(WIDTH-1) exactly.
    always_comb begin
        mag1 = (signed_mode && in1[WIDTH-1]) ? (~in1 + WIDTH'(1)) : in1;
        mag2 = (signed_mode && in2[WIDTH-1]) ? (~in2 + WIDTH'(1)) : in2;
    end

    mult_pp_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .STEP_W         (STEP_W)
    ) u_pp_step (
        .acc      (acc),
        .mcand    (mcand),
        .bits     (mplier[BITS_PER_CYCLE-1:0]),
        .step     (count),
        .acc_next (acc_next)
    );

    // BUSY runs N accumulate iterations; the cycle after the last one applies
    // the sign correction into the output register and enters DONE, giving
    // out_valid N+1 edges after acceptance regardless of operand values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            acc       <= '0;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            negate    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        mplier   <= mag1;
                        mcand    <= mag2;
                        negate   <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (count == STEP_W'(N_STEPS)) begin
                        out       <= negate ? (~acc + PW'(1)) : acc;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        acc    <= acc_next;
                        mplier <= mplier >> BITS_PER_CYCLE;
                        count  <= count + STEP_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combinational_multi_cycle_mult.sv
// Directed bench for combinational_multi_cycle_mult: default 8-bit/1-bit
// instance plus a 16-bit/4-bits-per-cycle instance.
module tb_combinational_multi_cycle_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=8, BITS_PER_CYCLE=1
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [7:0]  in1, in2;
    logic [15:0] out;

    // WIDTH=16, BITS_PER_CYCLE=4
    logic        w_in_valid, w_in_ready, w_signed_mode, w_out_valid, w_out_ready;
    logic [15:0] w_in1, w_in2;
    logic [31:0] w_out;

    combinational_multi_cycle_mult #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    combinational_multi_cycle_mult #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in1(w_in1), .in2(w_in2), .signed_mode(w_signed_mode),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out(w_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered #1 after a rising edge with the DUT idle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input int hold, input logic [15:0] exp);
        int w;
        int lat;
        in1 = a; in2 = b; signed_mode = sm; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 30) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        @(posedge clk); #1;
        // scrambled inputs while busy must not disturb the captured operands
        in_valid = 1'b0; in1 = ~a; in2 = ~b; signed_mode = ~sm;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency8", lat, 9);
        chk("product8", out, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out8", out, exp);
            chk("hold_valid8", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_valid8", out_valid, 0);
        chk("post_hs_ready8", in_ready, 1);
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                           input logic [31:0] exp);
        int lat;
        w_in1 = a; w_in2 = b; w_signed_mode = sm; w_in_valid = 1'b1;
        chk("in_ready16", w_in_ready, 1);
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_in1 = '0; w_in2 = '0;
        lat = 0;
        while (!w_out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency16", lat, 5);
        chk("product16", w_out, exp);
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        chk("post_hs_valid16", w_out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int lat;
        int seen;
        logic [7:0]  ra, rb;
        logic        rsm;
        logic [15:0] up;
        logic signed [15:0] sp;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
        vecs[3]  = '{8'h00, 8'h00, 1'b0, 16'h0000};
        vecs[4]  = '{8'hFF, 8'h00, 1'b1, 16'h0000};
        vecs[5]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
        vecs[6]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[7]  = '{8'h80, 8'hFF, 1'b1, 16'h0080};
        vecs[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[9]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[10] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[11] = '{8'h0C, 8'h0D, 1'b0, 16'h009C};
        vecs[12] = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};
        vecs[13] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
        vecs[14] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
        vecs[15] = '{8'hAA, 8'h55, 1'b0, 16'h3872};

        rst = 1'b1;
        in_valid = 1'b0; in1 = '0; in2 = '0; signed_mode = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in1 = '0; w_in2 = '0; w_signed_mode = 1'b0; w_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_in_ready16", w_in_ready, 1);
        chk("rst_out_valid16", w_out_valid, 0);
        rst = 1'b0;

        // First op is offered right away: must be taken on the first edge.
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sm, i % 3, vecs[i].p);
        end

        // Backpressure with a new pair held on the input side.
        in1 = 8'h0C; in2 = 8'h0D; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in1 = 8'h02; in2 = 8'h03;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp_latency", lat, 9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out", out, 16'h009C);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_hs_valid", out_valid, 0);
        chk("bp_hs_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp2_latency", lat, 9);
        chk("bp2_out", out, 16'h0006);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during BUSY abandons the operation.
        in1 = 8'hFF; in2 = 8'hFF; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out", out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_stale_valid", seen, 0);
        do_op(8'h03, 8'h05, 1'b0, 0, 16'h000F);

        // Wide instance, four bits per iteration.
        do_op16(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE);
        do_op16(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
        do_op16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        do_op16(16'h1234, 16'h5678, 1'b0, 32'h06260060);

        // Random pairs in both modes with reference arithmetic.
        for (int r = 0; r < 200; r++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rsm = 1'($urandom);
            if (r % 10 == 0) ra = 8'h00;
            if (r % 10 == 1) ra = 8'hFF;
            if (r % 10 == 2) rb = 8'hFF;
            if (r % 10 == 3) rb = 8'h00;
            if (rsm) begin
                sp = $signed(ra) * $signed(rb);
                up = sp;
            end else begin
                up = ra * rb;
            end
            do_op(ra, rb, rsm, int'($urandom_range(0, 3)), up);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/combinational_multi_cycle_mult.md
COMBINATIONAL_MULTI_CYCLE_MULT -- requirements
Module: combinational_multi_cycle_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal 2..64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: multiplier bits retired per cycle, legal 1..WIDTH, must divide WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port in1  input  WIDTH  multiplier operand.
REQ-008 SHALL have port in2  input  WIDTH  multiplicand operand.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-010 SHALL have port out_valid  output  1  product available.
REQ-011 SHALL have port out_ready  input  1  consumer takes product.
REQ-012 SHALL have port out  output  2*WIDTH  product.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept operands on a rising edge with in_valid && in_ready, capturing in1, in2, signed_mode, and moving IDLE->BUSY.
REQ-016 SHALL remain in BUSY for exactly N = WIDTH/BITS_PER_CYCLE cycles, retiring BITS_PER_CYCLE multiplier bits (LSB first) per cycle via conditional shifted-add into a 2*WIDTH accumulator, then move BUSY->DONE.
REQ-017 SHALL assert out_valid N+1 cycles after the acceptance edge (N=8 at defaults).
REQ-018 SHALL hold out and out_valid stable in DONE until out_valid && out_ready, then move DONE->IDLE; in_ready rises the following cycle.
REQ-019 SHALL ignore in_valid, in1, in2, signed_mode while BUSY or DONE; captured values are not altered.
REQ-020 SHALL, in unsigned mode, produce the exact 2*WIDTH-bit product; no truncation or overflow.
REQ-021 SHALL, in signed mode, multiply operand magnitudes (WIDTH-bit unsigned, so -2^(WIDTH-1) is exact) and negate the final product when operand signs differ; result is exact two's-complement 2*WIDTH bits.
REQ-022 SHALL skip no cycles for zero operands; latency is data-independent.
REQ-023 SHALL keep out at its last value outside DONE (not required to be meaningful).

Reset
REQ-024 SHALL, on rst assertion, immediately force state IDLE, in_ready=1, out_valid=0, out=0, accumulator and bit counter =0.
REQ-025 SHALL abandon any in-flight operation on reset; no product is emitted for it after reset release.
REQ-026 SHALL accept new operands on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place the FSM state enum and a helper function computing N from parameters in shared package mult_pkg.
REQ-028 SHALL instantiate one sub-module mult_pp_step: combinational partial-product adder taking accumulator, multiplicand, BITS_PER_CYCLE multiplier bits and step index, returning updated accumulator.
REQ-029 SHALL check WIDTH % BITS_PER_CYCLE == 0 at elaboration and fail otherwise.

Verification
REQ-030 Unsigned defaults: in1=255, in2=255, signed_mode=0 -> out=16'hFE01, out_valid exactly 9 cycles after acceptance.
REQ-031 Signed defaults: in1=8'h80, in2=8'h80 -> out=16'h4000; in1=8'hFF, in2=8'h7F -> out=16'hFF81.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE, in_valid held high with new data -> out stable, in_ready=0, second operand accepted only after product handshake.
REQ-033 Reset mid-BUSY: assert rst at BUSY cycle 3 -> out_valid=0, in_ready=1 immediately; next accepted pair 3*5 -> out=15, no stale output.
REQ-034 WIDTH=16, BITS_PER_CYCLE=4: in1=16'hFFFF, in2=16'h0002 unsigned -> out=32'h0001FFFE after 5 cycles; signed -> 32'hFFFFFFFE.
REQ-035 Random regression: 10k pairs both modes, random valid/ready gaps, vs reference product; zero and all-ones operands forced.
